// File: rtl/stream_extreme_select.sv
// Serial reducer: splits an unsigned stream into groups of GROUP_SIZE elements
// and reports each group's max (or min) value together with its arrival index.
module stream_extreme_select #(
  parameter int DATA_WIDTH      = 8,
  parameter int GROUP_SIZE      = 3,
  parameter int GREATER_OR_LESS = 0,
  localparam int IDX_WIDTH      = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]  out_index,
  output logic                  busy
);

  // Handshake: a beat moves on a rising edge where valid & ready are both high;
  // out_valid never drops and out_data/out_index never change until accepted.
  localparam logic [1:0] ST_FIRST = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(GROUP_SIZE - 1);

  logic [1:0]            state_q, state_d;
  logic [IDX_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] best_val_q, best_val_d;
  logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;

  logic in_xfer;
  logic out_xfer;
  logic better;
  logic load_first;

  assign out_valid = (state_q == ST_HOLD);
  assign in_ready  = (state_q != ST_HOLD) | out_ready;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign out_data  = out_valid ? best_val_q : '0;
  assign out_index = out_valid ? best_idx_q : '0;
  assign busy      = (count_q != '0);

  // Strict compare: an equal value never displaces the earlier element.
  assign better = (GREATER_OR_LESS != 0) ? (in_data < best_val_q)
                                         : (in_data > best_val_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    load_first = 1'b0;
    case (state_q)
      ST_FIRST: begin
        if (in_xfer) load_first = 1'b1;
      end
      ST_ACCUM: begin
        if (in_xfer) begin
          if (better) begin
            best_val_d = in_data;
            best_idx_d = count_q;
          end
          if (count_q == LAST_IDX) begin
            state_d = ST_HOLD;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (out_xfer) begin
          if (in_xfer) begin
            load_first = 1'b1;
          end else begin
            state_d = ST_FIRST;
            count_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_FIRST;
        count_d = '0;
      end
    endcase
    // Element 0 of a group, whether it arrives in FIRST or overlaps a HOLD drain.
    if (load_first) begin
      best_val_d = in_data;
      best_idx_d = '0;
      if (GROUP_SIZE == 1) begin
        state_d = ST_HOLD;
        count_d = '0;
      end else begin
        state_d = ST_ACCUM;
        count_d = IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_FIRST;
      count_q    <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
    end
  end

endmodule

// File: tb/tb_stream_extreme_select.sv
// Bench for stream_extreme_select: three instances (max/3, min/3, max/1) fed
// one at a time; results are checked against a queue of expected {data,index}.
module tb_stream_extreme_select;

  logic       clk;
  logic       reset_n;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [7:0] in_data   [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] out_data  [3];
  logic [1:0] out_index [3];
  logic       busy      [3];
  logic       idx_g1;

  int n_checks;
  int n_fail;

  logic [9:0] exp_q[$];
  logic [9:0] sb_e;

  typedef struct {
    int         sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] exp_data;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t vecs[8];

  stream_extreme_select #(.DATA_WIDTH(8), .GROUP_SIZE(3), .GREATER_OR_LESS(0)) u_max3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_index(out_index[0]), .busy(busy[0])
  );

  stream_extreme_select #(.DATA_WIDTH(8), .GROUP_SIZE(3), .GREATER_OR_LESS(1)) u_min3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_index(out_index[1]), .busy(busy[1])
  );

  stream_extreme_select #(.DATA_WIDTH(8), .GROUP_SIZE(1), .GREATER_OR_LESS(0)) u_max1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_index(idx_g1), .busy(busy[2])
  );

  assign out_index[2] = {1'b0, idx_g1};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drivers
  task automatic send(input int sel, input logic [7:0] v);
    int t;
    t = 0;
    in_valid[sel] = 1'b1;
    in_data[sel]  = v;
    @(negedge clk);
    while (!in_ready[sel] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: dut%0d in_ready stayed 0, expected 1", sel);
    end
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] i);
    exp_q.push_back({d, i});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on every output transfer of any instance
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (reset_n && out_valid[d] && out_ready[d]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: dut%0d gave data %0h index %0h, expected no result",
                   d, out_data[d], out_index[d]);
        end else begin
          sb_e = exp_q.pop_front();
          check($sformatf("sb_data_dut%0d", d), 32'(out_data[d]), 32'(sb_e[9:2]));
          check($sformatf("sb_index_dut%0d", d), 32'(out_index[d]), 32'(sb_e[1:0]));
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = 8'h00;
      out_ready[d] = 1'b1;
    end

    vecs[0] = '{1, 8'd7,   8'd3,   8'd3,   8'd3,   2'd1};
    vecs[1] = '{1, 8'd4,   8'd4,   8'd4,   8'd4,   2'd0};
    vecs[2] = '{1, 8'd255, 8'd0,   8'd0,   8'd0,   2'd1};
    vecs[3] = '{1, 8'd9,   8'd8,   8'd1,   8'd1,   2'd2};
    vecs[4] = '{0, 8'd1,   8'd2,   8'd3,   8'd3,   2'd2};
    vecs[5] = '{0, 8'd255, 8'd255, 8'd254, 8'd255, 2'd0};
    vecs[6] = '{0, 8'd0,   8'd0,   8'd0,   8'd0,   2'd0};
    vecs[7] = '{0, 8'd100, 8'd200, 8'd200, 8'd200, 2'd1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_out_data", 32'(out_data[0]), 32'd0);
    check("rst_out_index", 32'(out_index[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;

    // Max of 5, 9, 2: valid appears for exactly one cycle
    push_exp(8'd9, 2'd1);
    send(0, 8'd5);
    send(0, 8'd9);
    check("t1_busy_mid", 32'(busy[0]), 32'd1);
    check("t1_valid_early", 32'(out_valid[0]), 32'd0);
    send(0, 8'd2);
    check("t1_valid_rise", 32'(out_valid[0]), 32'd1);
    check("t1_busy_hold", 32'(busy[0]), 32'd0);
    idle(1);
    check("t1_valid_fall", 32'(out_valid[0]), 32'd0);

    // Table of groups, applied back-to-back
    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].exp_data, vecs[i].exp_idx);
      send(vecs[i].sel, vecs[i].a);
      send(vecs[i].sel, vecs[i].b);
      send(vecs[i].sel, vecs[i].c);
    end
    idle(3);
    check("tbl_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure: result held, input stalled, then overlapped drain+load
    out_ready[0] = 1'b0;
    push_exp(8'd8, 2'd1);
    send(0, 8'd1);
    send(0, 8'd8);
    send(0, 8'd8);
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'd77;
      @(negedge clk);
      check("bp_valid", 32'(out_valid[0]), 32'd1);
      check("bp_data", 32'(out_data[0]), 32'd8);
      check("bp_index", 32'(out_index[0]), 32'd1);
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    push_exp(8'd255, 2'd2);
    send(0, 8'd200);
    check("bp_valid_drop", 32'(out_valid[0]), 32'd0);
    check("bp_busy_next", 32'(busy[0]), 32'd1);
    send(0, 8'd0);
    send(0, 8'd255);
    idle(2);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Gaps on in_valid
    push_exp(8'd20, 2'd1);
    send(0, 8'd10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("gap_busy", 32'(busy[0]), 32'd1);
      check("gap_valid", 32'(out_valid[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    send(0, 8'd20);
    @(negedge clk);
    check("gap_busy2", 32'(busy[0]), 32'd1);
    @(posedge clk);
    #1;
    send(0, 8'd15);
    idle(2);
    check("gap_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-group discards the partial group
    send(0, 8'd50);
    send(0, 8'd60);
    #1;
    check("rstmid_busy_before", 32'(busy[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_out_valid", 32'(out_valid[0]), 32'd0);
    check("rstmid_busy", 32'(busy[0]), 32'd0);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(8'd3, 2'd2);
    send(0, 8'd1);
    send(0, 8'd2);
    send(0, 8'd3);
    idle(2);
    check("rstmid_drained", 32'(exp_q.size()), 32'd0);

    // GROUP_SIZE = 1: one result per cycle, index always 0
    push_exp(8'hAA, 2'd0);
    push_exp(8'h55, 2'd0);
    send(2, 8'hAA);
    check("g1_valid_a", 32'(out_valid[2]), 32'd1);
    check("g1_data_a", 32'(out_data[2]), 32'hAA);
    send(2, 8'h55);
    check("g1_valid_b", 32'(out_valid[2]), 32'd1);
    check("g1_data_b", 32'(out_data[2]), 32'h55);
    check("g1_busy", 32'(busy[2]), 32'd0);
    idle(1);
    check("g1_valid_fall", 32'(out_valid[2]), 32'd0);
    idle(2);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stream_extreme_select.md
Name: stream_extreme_select

Overview:
- Sequential reducer that accepts a stream of unsigned values over a valid/ready handshake.
- Groups the stream into fixed groups of GROUP_SIZE elements.
- For each group, emits the extreme value (max or min) and its position within the group.
- Sits downstream of operand producers and feeds selection logic that needs a winner index, where the combinational 3-way select is too wide or the operands arrive serially.

Parameters:
- DATA_WIDTH, 8, width of each unsigned value.
- GROUP_SIZE, 3, elements per group; legal range 1..256.
- GREATER_OR_LESS, 0, selects the extreme: 0 = maximum, 1 = minimum.
- IDX_WIDTH, derived localparam, = max(1, clog2(GROUP_SIZE)); not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  DATA_WIDTH  candidate value.
- out_valid  output  1  result held on out_data/out_index.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DATA_WIDTH  extreme value of the completed group.
- out_index  output  IDX_WIDTH  position (0-based, arrival order) of that value in the group.
- busy  output  1  a group is partially accumulated (count != 0).

Behaviour:

Reset (reset_n low, asynchronous):
- State = FIRST, count = 0.
- out_valid = 0, out_data = 0, out_index = 0, busy = 0.
- in_ready follows state: it is 1 once reset is released.

Transfers:
- Input transfer = in_valid & in_ready.
- Output transfer = out_valid & out_ready.
- out_data and out_index are stable while out_valid = 1 and out_ready = 0.

States:
- FIRST: in_ready = 1. On an input transfer, load best_val = in_data, best_idx = 0, count = 1.
  - If GROUP_SIZE = 1, go to HOLD.
  - Otherwise go to ACCUM.
- ACCUM: in_ready = 1. On an input transfer, compare in_data against best_val.
  - Comparison is strict: greater-than when GREATER_OR_LESS = 0, less-than when it is 1.
  - If strictly better, replace best_val and set best_idx = count.
  - Ties keep the earlier element, so the lowest index wins.
  - count increments. When the accepted element is index GROUP_SIZE-1, go to HOLD.
  - With no input transfer, state holds; in_valid gaps are allowed.
- HOLD: out_valid = 1, out_data = best_val, out_index = best_idx. in_ready = out_ready.
  - Output transfer with no input transfer: go to FIRST, count = 0.
  - Output transfer with a simultaneous input transfer: that element is loaded as element 0 of the next group, exactly as in FIRST. Next state is ACCUM, or HOLD if GROUP_SIZE = 1.
  - This gives full throughput: one element per cycle sustained with out_ready held high.

Latency and flow:
- out_valid rises on the clock edge that accepts the last element of the group, i.e. it is visible the cycle after that transfer.
- At most one result is buffered. Back-pressure on out_ready stalls input through in_ready.

Widths and comparison:
- Unsigned comparison over the full DATA_WIDTH.
- count and best_idx are IDX_WIDTH bits and never exceed GROUP_SIZE-1. No wrap is possible within a group.

Other rules:
- busy = 1 in ACCUM, and in HOLD/FIRST only when a next-group element has been loaded.
- Reset asserted mid-group or mid-HOLD discards the partial group and any pending result. No result is emitted for it.
- in_data is ignored whenever in_ready = 0 or in_valid = 0.

Test Plan:
1. Max, GROUP_SIZE = 3, out_ready = 1. Stream 5, 9, 2 back-to-back.
   -> Result is out_data = 9, out_index = 1.
   -> out_valid is high for exactly one cycle, appearing the cycle after the transfer of 2.
2. Min, GROUP_SIZE = 3. Stream 7, 3, 3.
   -> Result is out_data = 3, out_index = 1 (tie keeps the earlier element).
   -> Then stream 4, 4, 4 -> out_data = 4, out_index = 0.
3. Back-pressure. Max, group 1, 8, 8 with out_ready = 0 for 4 cycles.
   -> out_data = 8 and out_index = 1 are held stable, and in_ready = 0 throughout.
   -> Raise out_ready together with in_valid = 1, in_data = 200: the result transfers and 200 is captured as element 0 of the next group.
   -> Continue with 0, 255 -> out_data = 255, out_index = 2.
4. Gaps. Max, GROUP_SIZE = 3. Stream 10, idle 3 cycles, 20, idle 1 cycle, 15.
   -> Result is out_data = 20, out_index = 1. busy is 1 throughout the gaps.
5. Reset mid-group. Accept 50, 60, then pulse reset_n low between clock edges.
   -> out_valid = 0 and busy = 0 immediately (asynchronously).
   -> After release, stream 1, 2, 3 (max) -> out_data = 3, out_index = 2; no stale result from the discarded group.
6. GROUP_SIZE = 1, continuous in_valid with out_ready = 1. Stream 0xAA, 0x55.
   -> Each value is emitted with out_index = 0, one result per cycle.
